bounce_gen: RTL
===============

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 100000: length of the bounce window, in clk cycles (>=1).
REQ-002 Parameter SETTLE_CYCLES, default 200000: length of the stable hold after the window, in clk cycles (>=1).
REQ-003 Parameter MIN_GLITCH, default 4: minimum segment dwell, in cycles (>=1).
REQ-004 Parameter GLITCH_W, default 6: width of the random part of the segment dwell (1..8).
REQ-005 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 req_valid  input  1  request for a new button level.
REQ-009 req_level  input  1  target level (1=pressed); sampled when accepted.
REQ-010 req_ready  output  1  high only in IDLE.
REQ-011 bounce_out  output  1  emulated raw button line; drives the debouncer input.
REQ-012 busy  output  1  high in BOUNCE and SETTLE.
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 edge_count  output  16  bounce_out transition count (see Configuration).

Function
REQ-015 The FSM SHALL have three states: IDLE, BOUNCE and SETTLE.
REQ-016 A request SHALL be accepted on a cycle with req_valid && req_ready.
REQ-017 If accepted req_level equals bounce_out, the block SHALL stay IDLE, leave bounce_out unchanged and pulse done the next cycle.
REQ-018 Otherwise the block SHALL enter BOUNCE, and bounce_out SHALL equal req_level the cycle after acceptance.
REQ-019 In BOUNCE, bounce_out SHALL toggle at the end of each segment.
REQ-020 Segment length SHALL be MIN_GLITCH + lfsr[GLITCH_W-1:0] cycles, with the LFSR value captured at the segment start.
REQ-021 The LFSR SHALL be a 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing every cycle in BOUNCE only.
REQ-022 The window counter SHALL count BOUNCE_CYCLES cycles, starting the cycle after acceptance.
REQ-023 When the window expires, bounce_out SHALL be forced to the target regardless of segment position, and the FSM SHALL enter SETTLE.
REQ-024 A toggle coinciding with expiry SHALL be suppressed.
REQ-025 SETTLE SHALL hold bounce_out at the target for SETTLE_CYCLES cycles, then enter IDLE and pulse done in the same cycle.
REQ-026 Acceptance-to-done latency SHALL be exactly BOUNCE_CYCLES+SETTLE_CYCLES+1 cycles.
REQ-027 req_valid outside IDLE SHALL be ignored, not queued.
REQ-028 A request may be accepted in the same cycle done pulses.
REQ-029 Counters SHALL be sized $clog2(param+1) and SHALL saturate, never wrap.

Reset
REQ-030 With rst_n low at a clk edge, reset SHALL force: state IDLE, bounce_out 0, busy 0, done 0, req_ready 1, LFSR to LFSR_SEED, counters 0, edge_count 0.
REQ-031 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the operation with no done pulse.

Configuration
REQ-032 With BOUNCE_GEN_STATS_EN defined, edge_count SHALL increment on every bounce_out transition, saturating at 16'hFFFF, and clear only on reset.
REQ-033 Without BOUNCE_GEN_STATS_EN, edge_count SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-034 Package bounce_gen_pkg SHALL hold the state enum, the LFSR width, the polynomial tap constant and the zero-seed substitute.
REQ-035 The LFSR SHALL be sub-module lfsr16 (ports: clk, rst_n, en, seed, q).

Verification
Bench parameters: BOUNCE_CYCLES=100, SETTLE_CYCLES=50, MIN_GLITCH=2, GLITCH_W=3.
REQ-036 Reset, then req_level=1 -> bounce_out=1 at +1, >=1 toggle in window, bounce_out=1 from +100, done at +151.
REQ-037 Then req_level=1 again -> no bounce_out change, done at +1.
REQ-038 Measure all segment widths in a 1->0 request -> every width in 2..9, every toggle inside the window.
REQ-039 req_valid held high during BOUNCE -> req_ready=0, no second acceptance, done pulses exactly once.
REQ-040 rst_n low at +40 into BOUNCE -> bounce_out=0, req_ready=1, no done pulse; a new request then completes normally.
REQ-041 STATS_EN build, two full requests -> edge_count equals the transitions counted by the bench; non-STATS build -> edge_count=0.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg
// Shared definitions for the button-bounce generator:
//   - state_e        : controller states (IDLE, BOUNCE, SETTLE)
//   - LFSR_W         : width of the pseudo-random generator
//   - LFSR_TAPS      : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - LFSR_ZERO_SUB  : seed used when the configured seed is zero
//   - lfsr_step()    : one right-shifting Galois LFSR step
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int          LFSR_W        = 16;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

    // Right-shifting Galois form: the bit shifted out feeds back into the taps.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// lfsr16
// 16-bit Galois LFSR that only advances while enabled.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, loads the seed
//   en    : advance one step this cycle
//   seed  : reset value (zero is replaced so the register never locks up)
//   q     : current LFSR state
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = en ? lfsr_step(lfsr_q) : lfsr_q;
    end

    // The all-zero state is a fixed point of the LFSR, so it is never loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// bounce_gen
// Emulates a bouncing mechanical button. On a request for a new level the
// output chatters with pseudo-random segment lengths for a fixed window,
// is then forced to the target and held for a settle period, then done pulses.
// Optional feature macro: BOUNCE_GEN_STATS_EN enables the edge_count counter;
// without it edge_count is tied to zero.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : request for a new button level
//   req_level  : requested level (1 = pressed), sampled on acceptance
//   req_ready  : high only while idle
//   bounce_out : emulated raw button line
//   busy       : high while bouncing or settling
//   done       : one-cycle pulse when a request completes
//   edge_count : number of bounce_out transitions (stats build only)
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 100000,
    parameter int          SETTLE_CYCLES = 200000,
    parameter int          MIN_GLITCH    = 4,
    parameter int          GLITCH_W      = 6,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_level,
    output logic        req_ready,
    output logic        bounce_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] edge_count
);

    localparam int WIN_W   = $clog2(BOUNCE_CYCLES + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int SEG_MAX = MIN_GLITCH + (1 << GLITCH_W) - 1;
    localparam int SEG_W   = $clog2(SEG_MAX + 1);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(BOUNCE_CYCLES);
    localparam logic [WIN_W-1:0] WIN_FORCE = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES);
    localparam logic [SEG_W-1:0] SEG_MIN   = SEG_W'(MIN_GLITCH);

    state_e            state_q, state_d;
    logic              bounce_q, bounce_d;
    logic              target_q, target_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [SEG_W-1:0]  seg_len_q, seg_len_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [SEG_W-1:0]  new_seg_len;
    logic              lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_BOUNCE),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low GLITCH_W bits randomise the dwell; the rest are ignored.
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:GLITCH_W];
    assign new_seg_len = SEG_MIN + SEG_W'(lfsr_q[GLITCH_W-1:0]);

    // Next-state logic. The output is forced to the target on the edge into
    // the last window cycle, so any toggle due at expiry is swallowed and the
    // line is already stable for the whole final window cycle.
    always_comb begin
        state_d   = state_q;
        bounce_d  = bounce_q;
        target_d  = target_q;
        win_cnt_d = win_cnt_q;
        set_cnt_d = set_cnt_q;
        seg_cnt_d = seg_cnt_q;
        seg_len_d = seg_len_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    target_d = req_level;
                    if (req_level == bounce_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_BOUNCE;
                        bounce_d  = req_level;
                        win_cnt_d = WIN_W'(1);
                        set_cnt_d = '0;
                        seg_cnt_d = SEG_W'(1);
                        seg_len_d = new_seg_len;
                    end
                end
            end
            ST_BOUNCE: begin
                win_cnt_d = (win_cnt_q == WIN_LAST) ? win_cnt_q : win_cnt_q + WIN_W'(1);
                seg_cnt_d = (seg_cnt_q == SEG_W'(SEG_MAX)) ? seg_cnt_q : seg_cnt_q + SEG_W'(1);
                if (win_cnt_q >= WIN_LAST) begin
                    state_d   = ST_SETTLE;
                    bounce_d  = target_q;
                    set_cnt_d = SET_W'(1);
                end else if (win_cnt_q >= WIN_FORCE) begin
                    bounce_d = target_q;
                end else if (seg_cnt_q >= seg_len_q) begin
                    bounce_d  = ~bounce_q;
                    seg_cnt_d = SEG_W'(1);
                    seg_len_d = new_seg_len;
                end
            end
            ST_SETTLE: begin
                bounce_d = target_q;
                if (set_cnt_q >= SET_LAST) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    set_cnt_d = '0;
                    win_cnt_d = '0;
                    seg_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bounce_q  <= 1'b0;
            target_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            win_cnt_q <= '0;
            set_cnt_q <= '0;
            seg_cnt_q <= '0;
            seg_len_q <= '0;
        end else begin
            state_q   <= state_d;
            bounce_q  <= bounce_d;
            target_q  <= target_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            win_cnt_q <= win_cnt_d;
            set_cnt_q <= set_cnt_d;
            seg_cnt_q <= seg_cnt_d;
            seg_len_q <= seg_len_d;
        end
    end

    assign req_ready  = ready_q;
    assign bounce_out = bounce_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef BOUNCE_GEN_STATS_EN
    logic [15:0] edge_cnt_q;
    logic [15:0] edge_cnt_d;

    // Counts the transition about to be registered; saturates at all-ones.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if ((bounce_d != bounce_q) && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_count = edge_cnt_q;
`else
    assign edge_count = '0;
`endif

endmodule
